ddr3_pg_arb: RTL



---
 rtl/hbuf_pkg.sv | 16 +
 rtl/pg_arb_rr_pick.sv | 31 +++
 rtl/ddr3_pg_arb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hbuf_pkg.sv
// Shared definitions for the hit-buffer DDR3 page path: FSM state
// encodings, page address width and operation type codes.
package hbuf_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_REL  = 2'd3
    } pg_state_e;

    localparam int   PG_ADDR_W = 28;
    localparam logic OPTYPE_WR = 1'b1;
    localparam logic OPTYPE_RD = 1'b0;

endpackage

// File: rtl/pg_arb_rr_pick.sv
// Combinational round-robin picker: finds the first asserted request
// starting one position after last and wrapping around. valid is low
// when no request is asserted (idx is then 0).
module pg_arb_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last,
    output logic         valid,
    output logic [1:0]   idx
);

    int pos;

    // Walk the N candidate positions after last, keeping the first hit.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        pos   = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(last) + k) % N;
            for (int i = 0; i < N; i++) begin
                if (!valid && (i == pos) && req[i]) begin
                    valid = 1'b1;
                    idx   = 2'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ddr3_pg_arb.sv
// Round-robin arbiter sharing the DDR3 page-transfer engine between
// several page requesters. Optional watchdog on the engine ack is
// enabled by defining PG_ARB_TIMEOUT_EN.
//
// Handshake: both sides are four-phase. A requester raises req_in[i]
// with optype/addr valid and holds it until ack_out[i] rises, then drops
// req_in[i]; ack_out[i] falls after that. Towards the engine pg_req
// rises, stays high until pg_ack rises, then falls; the arbiter waits
// for pg_ack to fall before taking a new request.
module ddr3_pg_arb
    import hbuf_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = PG_ADDR_W,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_in,
    input  logic [N_REQ-1:0]        optype_in,
    input  logic [N_REQ*ADDR_W-1:0] addr_in,
    output logic [N_REQ-1:0]        ack_out,
    output logic [1:0]              grant_sel,
    output logic                    busy,
    output logic                    pg_req,
    output logic                    pg_optype,
    output logic [ADDR_W-1:0]       pg_addr,
    input  logic                    pg_ack,
    output logic                    err_timeout,
    input  logic                    err_clr,
    output logic [1:0]              state_dbg
);

    pg_state_e          state;
    logic [1:0]         last_grant;
    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic               sel_optype;
    logic [ADDR_W-1:0]  sel_addr;
    logic               grant_req;
    logic [N_REQ-1:0]   grant_oh;
    logic               tmo_hit;

    pg_arb_rr_pick #(.N(N_REQ)) u_pick (
        .req   (req_in),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Select the picked requester's op/address and the granted requester's req line.
    always_comb begin
        sel_optype = 1'b0;
        sel_addr   = '0;
        grant_req  = 1'b0;
        grant_oh   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == 2'(i)) begin
                sel_optype = optype_in[i];
                sel_addr   = addr_in[i*ADDR_W +: ADDR_W];
            end
            if (grant_sel == 2'(i)) begin
                grant_req   = req_in[i];
                grant_oh[i] = 1'b1;
            end
        end
    end

`ifdef PG_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] tmo_cnt;

    assign tmo_hit = (state == S_REQ) && (tmo_cnt == TMO_LAST);

    // Count cycles spent waiting for pg_ack; cleared whenever not in S_REQ.
    always_ff @(posedge clk) begin
        if (rst || state != S_REQ)
            tmo_cnt <= 16'd0;
        else
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Sticky timeout flag; a new timeout outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)
            err_timeout <= 1'b0;
        else if (tmo_hit && !pg_ack)
            err_timeout <= 1'b1;
        else if (err_clr)
            err_timeout <= 1'b0;
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign tmo_hit        = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    // Arbitration FSM: grant in S_IDLE, drive the engine, then close both handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 2'(N_REQ - 1);
            grant_sel  <= 2'd0;
            pg_req     <= 1'b0;
            pg_optype  <= 1'b0;
            pg_addr    <= '0;
            ack_out    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_sel  <= pick_idx;
                        last_grant <= pick_idx;
                        pg_optype  <= sel_optype;
                        pg_addr    <= sel_addr;
                        pg_req     <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (pg_ack || tmo_hit) begin
                        pg_req  <= 1'b0;
                        ack_out <= grant_oh;
                        state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!grant_req) begin
                        ack_out <= '0;
                        state   <= S_REL;
                    end
                end
                S_REL: begin
                    if (!pg_ack)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule
